seg_shift_out: RTL and testbench
================================

SEG_SHIFT_OUT -- requirements
Module: seg_shift_out

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 2, setting the clk cycles per seg_clk half-period (legal range 1..255).
REQ-002 The module SHALL have parameter FRAME_BITS, default 64, setting the number of bits per frame (fixed, from package).
REQ-003 The clock port SHALL be: clk  input  1  system clock, all logic rising-edge.
REQ-004 The reset port SHALL be: rst  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port: start  input  1  frame request, sampled only in IDLE.
REQ-006 The module SHALL have port: seg_txt  input  64  segment pattern from hex-to-segment stage, eight 8-bit digits, digit 7 in [7:0].
REQ-007 The module SHALL have port: seg_clk  output  1  shift clock to the 74HC595 chain.
REQ-008 The module SHALL have port: seg_sout  output  1  serial data to the chain.
REQ-009 The module SHALL have port: seg_pen  output  1  latch/output-enable strobe, active-high.
REQ-010 The module SHALL have port: seg_clrn  output  1  chain clear, active-low.
REQ-011 The module SHALL have port: busy  output  1  frame in progress.
REQ-012 The module SHALL have port: done  output  1  one-cycle end-of-frame pulse.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT_LO, SHIFT_HI and LATCH.
REQ-014 In IDLE with start=1, the block SHALL snapshot seg_txt into a 64-bit shift register, clear bit_cnt to 0 and enter SHIFT_LO on the next edge.
REQ-015 SHIFT_LO SHALL drive seg_clk=0 and seg_sout=shreg[63] for CLK_DIV cycles, then enter SHIFT_HI.
REQ-016 SHIFT_HI SHALL drive seg_clk=1 for CLK_DIV cycles; on exit it SHALL shift shreg left by one, increment bit_cnt, and enter SHIFT_LO if bit_cnt<63, else LATCH.
REQ-017 Transmission order SHALL be seg_txt[63] first and seg_txt[0] last.
REQ-018 LATCH SHALL drive seg_clk=0 and seg_pen=1 for CLK_DIV cycles, then return to IDLE with done=1 for exactly that one transition cycle.
REQ-019 seg_pen SHALL be 0 in every state other than LATCH.
REQ-020 busy SHALL be 1 in SHIFT_LO, SHIFT_HI and LATCH, and 0 in IDLE.
REQ-021 Frame length from start acceptance to done SHALL be exactly 129*CLK_DIV+1 clk cycles.
REQ-022 start asserted while busy=1 SHALL be ignored, not queued; seg_txt changes during a frame SHALL NOT affect it.
REQ-023 start asserted in the same cycle that done is high SHALL be accepted, giving back-to-back frames.
REQ-024 seg_clrn SHALL be 1 at all times except while rst=1.
REQ-025 The divider counter SHALL wrap to 0 at CLK_DIV-1 and SHALL reload on every state change.

Reset
REQ-026 While rst=1 the block SHALL force state IDLE, shreg=0, bit_cnt=0, seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0, busy=0 and done=0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no done pulse and no seg_pen pulse.

Configuration
REQ-028 With macro SEG_AUTO_REFRESH_EN defined, the block SHALL also start a frame from IDLE whenever seg_txt differs from the last transmitted frame, as if start=1.
REQ-029 With SEG_AUTO_REFRESH_EN undefined, frames SHALL start only on start, and the last-frame register SHALL NOT exist.
REQ-030 When SEG_AUTO_REFRESH_EN is defined, the last-frame register SHALL reset to 0, so a nonzero seg_txt after reset triggers one frame.

Structure
REQ-031 Package seg_pkg SHALL hold the FSM state typedef, FRAME_BITS=64 and the bit-counter width constant.
REQ-032 The divider SHALL be a sub-module seg_tick_gen that outputs a one-cycle tick every CLK_DIV cycles and restarts on its clear input.

Verification
REQ-033 CLK_DIV=2, seg_txt=64'h8000_0000_0000_0001, start pulse: first sout bit 1, bits 1..62 are 0, last bit 1, done 259 cycles after start.
REQ-034 The bench SHALL count seg_clk rising edges per frame and require exactly 64, plus exactly one seg_pen pulse of 2 cycles after the last edge.
REQ-035 start held high for 300 cycles SHALL yield two consecutive frames, the second starting in the done cycle.
REQ-036 Change seg_txt mid-frame from 64'hFFFF... to 0: the current frame SHALL complete with all-ones data.
REQ-037 rst at cycle 100 of a frame: all outputs SHALL reset the next edge, with no done and seg_clrn=0 while rst=1.
REQ-038 With SEG_AUTO_REFRESH_EN defined, changing seg_txt 64'h1234 to 64'h5678 SHALL trigger one frame with no start, and holding it steady SHALL trigger none.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 74HC595 segment shifter.
// FSM state encoding, frame size and counter widths.
package seg_pkg;

  localparam int FRAME_BITS = 64;
  localparam int BIT_CNT_W  = 6;
  localparam int DIV_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } seg_state_t;

endpackage

// File: rtl/seg_tick_gen.sv
// Phase divider: one-cycle tick every CLK_DIV clocks.
// Restarts from zero whenever i_clr is high.
module seg_tick_gen
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  // Count up, wrap on the terminal count, restart on clear
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_shift_out.sv
// Serialises a 64-bit segment frame into a 74HC595 chain, MSB first.
// Define SEG_AUTO_REFRESH_EN to also send a frame whenever seg_txt changes.
module seg_shift_out
  import seg_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = seg_pkg::FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] seg_txt,
  output logic                  seg_clk,
  output logic                  seg_sout,
  output logic                  seg_pen,
  output logic                  seg_clrn,
  output logic                  busy,
  output logic                  done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT =
    BIT_CNT_W'(FRAME_BITS - 1);

  seg_state_t              r_state;
  logic [FRAME_BITS-1:0]   r_shreg;
  logic [BIT_CNT_W-1:0]    r_bit_cnt;
  logic                    r_clk;
  logic                    r_sout;
  logic                    r_pen;
  logic                    r_busy;
  logic                    r_done;
  logic                    w_tick;
  logic                    w_go;
  logic                    w_clr;

  // Divider is held at zero in IDLE so every busy state starts fresh
  assign w_clr = (r_state == IDLE);

  seg_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

`ifdef SEG_AUTO_REFRESH_EN
  logic [FRAME_BITS-1:0] r_last;

  assign w_go = start || (seg_txt != r_last);

  // Remember the frame most recently sent, to detect changes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= '0;
    end else if (r_state == IDLE && w_go) begin
      r_last <= seg_txt;
    end
  end
`else
  assign w_go = start;
`endif

  // Frame sequencer with registered chain outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_clk     <= 1'b0;
      r_sout    <= 1'b0;
      r_pen     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_clk  <= 1'b0;
          r_pen  <= 1'b0;
          r_sout <= 1'b0;
          r_busy <= 1'b0;
          if (w_go) begin
            r_shreg   <= seg_txt;
            r_bit_cnt <= '0;
            r_sout    <= seg_txt[FRAME_BITS-1];
            r_busy    <= 1'b1;
            r_state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (w_tick) begin
            r_clk   <= 1'b1;
            r_state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (w_tick) begin
            r_shreg   <= {r_shreg[FRAME_BITS-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_clk     <= 1'b0;
            if (r_bit_cnt != LAST_BIT) begin
              r_sout  <= r_shreg[FRAME_BITS-2];
              r_state <= SHIFT_LO;
            end else begin
              r_pen   <= 1'b1;
              r_state <= LATCH;
            end
          end
        end
        LATCH: begin
          if (w_tick) begin
            r_pen   <= 1'b0;
            r_busy  <= 1'b0;
            r_sout  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign seg_clk  = r_clk;
  assign seg_sout = r_sout;
  assign seg_pen  = r_pen;
  assign busy     = r_busy;
  assign done     = r_done;
  assign seg_clrn = ~rst;

endmodule

// File: tb/tb_seg_shift_out.sv
// Directed bench for seg_shift_out with CLK_DIV=2.
// Decodes the serial stream and checks framing and timing.
module tb_seg_shift_out;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] seg_txt;
  logic        seg_clk;
  logic        seg_sout;
  logic        seg_pen;
  logic        seg_clrn;
  logic        busy;
  logic        done;

  int n_tests;
  int n_fail;

  logic [63:0] bits;
  int          edges;
  int          pens;
  int          pen_runs;
  int          pen_early;
  int          busy_cyc;
  int          cyc;
  bit          got;
  int          seen;

  seg_shift_out #(
    .CLK_DIV (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seg_txt  (seg_txt),
    .seg_clk  (seg_clk),
    .seg_sout (seg_sout),
    .seg_pen  (seg_pen),
    .seg_clrn (seg_clrn),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Follow one frame until done; start drops at cycle drop_at
  task automatic watch(input int budget, input int drop_at);
    logic pc;
    logic pp;
    pc        = seg_clk;
    pp        = seg_pen;
    bits      = '0;
    edges     = 0;
    pens      = 0;
    pen_runs  = 0;
    pen_early = 0;
    busy_cyc  = 0;
    cyc       = 0;
    got       = 1'b0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == drop_at) start = 1'b0;
      if (seg_clk && !pc) begin
        bits = {bits[62:0], seg_sout};
        edges++;
      end
      if (seg_pen) begin
        pens++;
        if (!pp) pen_runs++;
        if (edges != 64) pen_early++;
      end
      if (busy) busy_cyc++;
      pc = seg_clk;
      pp = seg_pen;
      if (done) got = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag,
                             input logic [63:0] exp);
    check({tag, "_done"}, 64'(got), 64'd1);
    check({tag, "_bits"}, bits, exp);
    check({tag, "_edges"}, 64'(edges), 64'd64);
    check({tag, "_pen_cyc"}, 64'(pens), 64'd2);
    check({tag, "_pen_runs"}, 64'(pen_runs), 64'd1);
    check({tag, "_pen_early"}, 64'(pen_early), 64'd0);
    check({tag, "_latency"}, 64'(cyc), 64'd259);
    check({tag, "_busy_cyc"}, 64'(busy_cyc), 64'd258);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    seg_txt = '0;
    repeat (3) @(negedge clk);
    check("rst_clk", 64'(seg_clk), 64'd0);
    check("rst_sout", 64'(seg_sout), 64'd0);
    check("rst_pen", 64'(seg_pen), 64'd0);
    check("rst_clrn", 64'(seg_clrn), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    #1;
    check("clrn_high", 64'(seg_clrn), 64'd1);
    repeat (3) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

`ifdef SEG_AUTO_REFRESH_EN
    seg_txt = 64'h1234;
    watch(400, 0);
    check_frame("auto1", 64'h1234);
    seg_txt = 64'h5678;
    watch(400, 0);
    check_frame("auto2", 64'h5678);
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy) seen++;
    end
    check("auto_steady", 64'(seen), 64'd0);
`else
    seg_txt = 64'h8000_0000_0000_0001;
    start   = 1'b1;
    watch(400, 1);
    check_frame("f1", 64'h8000_0000_0000_0001);
    check("f1_busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("f1_done_1cyc", 64'(done), 64'd0);
    check("f1_idle_after", 64'(busy), 64'd0);

    seg_txt = 64'hA5C3_0F96_1234_FEDC;
    start   = 1'b1;
    watch(400, 1000);
    check_frame("b2b1", 64'hA5C3_0F96_1234_FEDC);
    check("b2b1_start_hi", 64'(start), 64'd1);
    seg_txt = 64'h0123_4567_89AB_CDEF;
    watch(400, 41);
    check_frame("b2b2", 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    check("b2b_no_third", 64'(busy), 64'd0);

    seg_txt = 64'hFFFF_FFFF_FFFF_FFFF;
    start   = 1'b1;
    fork
      watch(400, 1);
      begin
        repeat (50) @(negedge clk);
        seg_txt = '0;
      end
    join
    check_frame("ones", 64'hFFFF_FFFF_FFFF_FFFF);

    seg_txt = 64'hDEAD_BEEF_CAFE_F00D;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_clrn", 64'(seg_clrn), 64'd0);
    seen = 0;
    @(negedge clk);
    check("abort_clk", 64'(seg_clk), 64'd0);
    check("abort_sout", 64'(seg_sout), 64'd0);
    check("abort_pen", 64'(seg_pen), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (3) begin
      if (done || seg_pen || seg_clrn) seen++;
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || seg_pen || busy) seen++;
    end
    check("abort_quiet", 64'(seen), 64'd0);
    check("abort_clrn_back", 64'(seg_clrn), 64'd1);

    seg_txt = 64'h0123_4567_89AB_CDEF;
    start   = 1'b1;
    watch(400, 1);
    check_frame("recover", 64'h0123_4567_89AB_CDEF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
